// File: rtl/pong_pkg.sv
// Shared constants for the pong VGA datapath.
// Screen geometry, colour codes and draw-engine state encoding.
package pong_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   localparam logic [COLOUR_W-1:0] BLACK   = 3'd0;
   localparam logic [COLOUR_W-1:0] BLUE    = 3'd1;
   localparam logic [COLOUR_W-1:0] GREEN   = 3'd2;
   localparam logic [COLOUR_W-1:0] CYAN    = 3'd3;
   localparam logic [COLOUR_W-1:0] RED     = 3'd4;
   localparam logic [COLOUR_W-1:0] MAGENTA = 3'd5;
   localparam logic [COLOUR_W-1:0] YELLOW  = 3'd6;
   localparam logic [COLOUR_W-1:0] WHITE   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } draw_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins.
// Pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_i,
   input  logic                 en_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] gidx_o,
   output logic                 any_o
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q, ptr_d, idx;

   always_comb begin
      gnt_o  = '0;
      gidx_o = '0;
      any_o  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_q) + k) % N);
         if (!any_o && req_i[idx]) begin
            any_o  = 1'b1;
            gidx_o = idx;
         end
      end
      if (any_o) gnt_o[gidx_o] = 1'b1;
   end

   assign ptr_d = (gidx_o == PW'(N - 1)) ? '0 : gidx_o + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else if (en_i && any_o) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the VGA pixel-write port among rectangle-drawing requesters,
// scanning the granted rectangle one pixel per clock.
module vga_draw_arbiter #(
   parameter int N_REQ    = 4,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*X_W-1:0]        rect_x,
   input  logic [N_REQ*Y_W-1:0]        rect_y,
   input  logic [N_REQ*X_W-1:0]        rect_w,
   input  logic [N_REQ*Y_W-1:0]        rect_h,
   input  logic [N_REQ*COLOUR_W-1:0]   rect_colour,
   output logic [N_REQ-1:0]            ack,
   output logic [N_REQ-1:0]            done,
   output logic                        busy,
   output logic [X_W-1:0]              x,
   output logic [Y_W-1:0]              y,
   output logic [COLOUR_W-1:0]         colour,
   output logic                        plot
);

   import pong_pkg::*;

   localparam int GW = $clog2(N_REQ);
   localparam logic [X_W:0] XLIM = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] YLIM = (Y_W+1)'(SCREEN_H);

   draw_state_e state_q, state_d;

   logic [X_W-1:0]      x0_q, x0_d, w_q, w_d, cx_q, cx_d;
   logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d, cy_q, cy_d;
   logic [COLOUR_W-1:0] col_q, col_d;
   logic [GW-1:0]       gid_q, gid_d;

   logic [N_REQ-1:0]    ack_q, ack_d, done_q, done_d;
   logic                busy_q, busy_d, plot_q, plot_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;

   logic [N_REQ-1:0]    gnt;
   logic [GW-1:0]       gidx;
   logic                any, arb_en;

   logic [X_W-1:0]      in_x, in_w;
   logic [Y_W-1:0]      in_y, in_h;
   logic [COLOUR_W-1:0] in_c;

   logic                emit;
   logic [X_W-1:0]      bx, ox;
   logic [Y_W-1:0]      by, oy;
   logic [COLOUR_W-1:0] bc;
   logic [X_W:0]        sx;
   logic [Y_W:0]        sy;

   assign arb_en = (state_q == ST_IDLE);

   rr_arbiter #(
      .N(N_REQ)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req),
      .en_i  (arb_en),
      .gnt_o (gnt),
      .gidx_o(gidx),
      .any_o (any)
   );

   assign in_x = rect_x[gidx*X_W +: X_W];
   assign in_y = rect_y[gidx*Y_W +: Y_W];
   assign in_w = rect_w[gidx*X_W +: X_W];
   assign in_h = rect_h[gidx*Y_W +: Y_W];
   assign in_c = rect_colour[gidx*COLOUR_W +: COLOUR_W];

   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      w_d      = w_q;
      h_d      = h_q;
      col_d    = col_q;
      gid_d    = gid_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      ack_d    = '0;
      done_d   = '0;
      busy_d   = busy_q;
      plot_d   = 1'b0;
      x_d      = '0;
      y_d      = '0;
      colour_d = BLACK;
      emit     = 1'b0;
      bx       = x0_q;
      by       = y0_q;
      ox       = cx_q;
      oy       = cy_q;
      bc       = col_q;
      sx       = '0;
      sy       = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (any) begin
               gid_d  = gidx;
               x0_d   = in_x;
               y0_d   = in_y;
               w_d    = in_w;
               h_d    = in_h;
               col_d  = in_c;
               ack_d  = gnt;
               busy_d = 1'b1;
               cx_d   = '0;
               cy_d   = '0;
               if (in_w == '0 || in_h == '0) begin
                  state_d = ST_DONE;
               end else begin
                  // First pixel leaves on the grant edge.
                  state_d = ST_DRAW;
                  emit    = 1'b1;
                  bx      = in_x;
                  by      = in_y;
                  ox      = '0;
                  oy      = '0;
                  bc      = in_c;
               end
            end
         end
         ST_DRAW: begin
            if (cx_q == w_q - 1'b1 && cy_q == h_q - 1'b1) begin
               state_d       = ST_DONE;
               done_d[gid_q] = 1'b1;
            end else begin
               if (cx_q == w_q - 1'b1) begin
                  cx_d = '0;
                  cy_d = cy_q + 1'b1;
               end else begin
                  cx_d = cx_q + 1'b1;
               end
               emit = 1'b1;
               ox   = cx_d;
               oy   = cy_d;
            end
         end
         ST_DONE: begin
            // Empty rectangles arrive here before done has pulsed.
            if (done_q == '0) begin
               done_d[gid_q] = 1'b1;
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      sx = {1'b0, bx} + {1'b0, ox};
      sy = {1'b0, by} + {1'b0, oy};
      if (emit) begin
         plot_d   = (sx < XLIM) && (sy < YLIM);
         x_d      = sx[X_W-1:0];
         y_d      = sy[Y_W-1:0];
         colour_d = bc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         gid_q    <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         ack_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         col_q    <= col_d;
         gid_q    <= gid_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         plot_q   <= plot_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
      end
   end

   assign ack    = ack_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign plot   = plot_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: transaction-level model plus directed
// vectors with literal expectations.
module tb_vga_draw_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;

   logic [7:0]  rx[4], rw[4];
   logic [6:0]  ry[4], rh[4];
   logic [2:0]  rc[4];

   logic [31:0] rect_x_v, rect_w_v;
   logic [27:0] rect_y_v, rect_h_v;
   logic [11:0] rect_c_v;

   logic [3:0]  ack, done;
   logic        busy, plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   always #5 clk = ~clk;

   always_comb begin
      rect_x_v = '0;
      rect_y_v = '0;
      rect_w_v = '0;
      rect_h_v = '0;
      rect_c_v = '0;
      for (int i = 0; i < 4; i++) begin
         rect_x_v[i*8 +: 8] = rx[i];
         rect_w_v[i*8 +: 8] = rw[i];
         rect_y_v[i*7 +: 7] = ry[i];
         rect_h_v[i*7 +: 7] = rh[i];
         rect_c_v[i*3 +: 3] = rc[i];
      end
   end

   vga_draw_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .rect_x     (rect_x_v),
      .rect_y     (rect_y_v),
      .rect_w     (rect_w_v),
      .rect_h     (rect_h_v),
      .rect_colour(rect_c_v),
      .ack        (ack),
      .done       (done),
      .busy       (busy),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot)
   );

   typedef struct {
      logic [3:0] ack;
      logic [3:0] done;
      logic       busy;
      logic       plot;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   mptr = 0;

   function automatic exp_t zero_e();
      exp_t z;
      z.ack = '0; z.done = '0; z.busy = 1'b0; z.plot = 1'b0;
      z.x = '0; z.y = '0; z.c = '0;
      return z;
   endfunction

   // Whole per-cycle output stream of one granted command.
   task automatic push_rect(input int g);
      exp_t it;
      int   sx, sy;
      bit   first;
      first = 1;
      if (rw[g] == 0 || rh[g] == 0) begin
         it = zero_e(); it.ack = 4'(1 << g); it.busy = 1'b1;
         q.push_back(it);
      end else begin
         for (int cy = 0; cy < int'(rh[g]); cy++) begin
            for (int cx = 0; cx < int'(rw[g]); cx++) begin
               it = zero_e();
               if (first) it.ack = 4'(1 << g);
               first = 0;
               it.busy = 1'b1;
               sx = int'(rx[g]) + cx;
               sy = int'(ry[g]) + cy;
               it.plot = (sx < 160) && (sy < 120);
               it.x = 8'(sx);
               it.y = 7'(sy);
               it.c = rc[g];
               q.push_back(it);
            end
         end
      end
      it = zero_e(); it.done = 4'(1 << g); it.busy = 1'b1;
      q.push_back(it);
      q.push_back(zero_e());
   endtask

   initial begin
      e = zero_e();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            q.delete();
            mptr = 0;
            e = zero_e();
         end else begin
            if (q.size() == 0) begin
               int g;
               logic [1:0] mi;
               g = -1;
               for (int k = 0; k < 4; k++) begin
                  mi = 2'((mptr + k) % 4);
                  if (g < 0 && req[mi]) g = int'(mi);
               end
               if (g >= 0) begin
                  mptr = (g + 1) % 4;
                  push_rect(g);
               end
            end
            if (q.size() > 0) e = q.pop_front();
            else e = zero_e();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            checks++;
            if ({ack, done, busy, plot} !== {e.ack, e.done, e.busy, e.plot}) begin
               errors++;
               $display("FAIL ctl t=%0t ack=%b/%b done=%b/%b busy=%b/%b plot=%b/%b (got/exp)",
                        $time, ack, e.ack, done, e.done, busy, e.busy, plot, e.plot);
            end
            if (e.plot) begin
               checks++;
               if ({x, y, colour} !== {e.x, e.y, e.c}) begin
                  errors++;
                  $display("FAIL pix t=%0t got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)",
                           $time, x, y, colour, e.x, e.y, e.c);
               end
            end
            if (!rst) begin
               checks++;
               if ({x, y, colour} !== 18'd0) begin
                  errors++;
                  $display("FAIL rst_pix t=%0t got (%0d,%0d,c%0d) exp 0",
                           $time, x, y, colour);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   logic [3:0] ack_l[64], done_l[64];
   logic       plot_l[64], busy_l[64];
   logic [7:0] x_l[64];
   logic [6:0] y_l[64];
   int         nl;
   bit         hold = 0;

   task automatic step();
      @(negedge clk);
      if (nl < 64) begin
         ack_l[nl]  = ack;
         done_l[nl] = done;
         plot_l[nl] = plot;
         busy_l[nl] = busy;
         x_l[nl]    = x;
         y_l[nl]    = y;
      end
      nl++;
      if (!hold) req = req & ~ack;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      req = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   int t1x[6] = '{10, 11, 10, 11, 10, 11};
   int t1y[6] = '{20, 20, 21, 21, 22, 22};
   int rr_ord[5] = '{0, 1, 2, 3, 0};
   int ord[5], pos[5];
   int na, cnt, cnt2;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         rx[i] = 8'(i * 20); ry[i] = 7'(i * 10);
         rw[i] = 8'd1; rh[i] = 7'd1; rc[i] = 3'(i + 1);
      end
      #1 rst = 1'b0;
      started = 1;
      @(negedge clk);
      chk("reset_ack", ack, 0);
      chk("reset_done", done, 0);
      chk("reset_busy_plot", {busy, plot}, 0);
      chk("reset_xyc", {x, y, colour}, 0);
      #2 rst = 1'b1;

      // Single 2x3 request
      @(negedge clk);
      rx[0] = 8'd10; ry[0] = 7'd20; rw[0] = 8'd2; rh[0] = 7'd3; rc[0] = 3'd7;
      req = 4'b0001;
      nl = 0;
      repeat (9) step();
      chk("t1_ack", ack_l[0], 4'b0001);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1_plot%0d", i), plot_l[i], 1);
         chk($sformatf("t1_x%0d", i), x_l[i], t1x[i]);
         chk($sformatf("t1_y%0d", i), y_l[i], t1y[i]);
      end
      chk("t1_done_early", done_l[5], 0);
      chk("t1_done", done_l[6], 4'b0001);
      chk("t1_busy_done", busy_l[6], 1);
      chk("t1_busy_idle", busy_l[7], 0);

      // Zero-width rectangle
      rx[1] = 8'd30; ry[1] = 7'd40; rw[1] = 8'd0; rh[1] = 7'd5; rc[1] = 3'd3;
      req = 4'b0010;
      nl = 0;
      repeat (4) step();
      chk("t2_ack", ack_l[0], 4'b0010);
      chk("t2_no_done_at_ack", done_l[0], 0);
      chk("t2_done", done_l[1], 4'b0010);
      chk("t2_busy_after", busy_l[2], 0);
      cnt = 0;
      for (int i = 0; i < 4; i++) if (plot_l[i]) cnt++;
      chk("t2_plots", cnt, 0);

      // Clipping at the bottom-right corner
      rx[3] = 8'd158; ry[3] = 7'd119; rw[3] = 8'd4; rh[3] = 7'd2; rc[3] = 3'd4;
      req = 4'b1000;
      nl = 0;
      repeat (11) step();
      cnt = 0;
      for (int i = 0; i < 11; i++) if (plot_l[i]) cnt++;
      chk("t3_plots", cnt, 2);
      chk("t3_p0", {plot_l[0], x_l[0], y_l[0]}, {1'b1, 8'd158, 7'd119});
      chk("t3_p1", {plot_l[1], x_l[1], y_l[1]}, {1'b1, 8'd159, 7'd119});
      chk("t3_p2_clip", plot_l[2], 0);
      chk("t3_busy_last", busy_l[7], 1);
      chk("t3_no_done_last", done_l[7], 0);
      chk("t3_done", done_l[8], 4'b1000);
      chk("t3_idle", busy_l[9], 0);

      // Withdrawn request while busy
      rx[0] = 8'd50; ry[0] = 7'd60; rw[0] = 8'd3; rh[0] = 7'd3; rc[0] = 3'd2;
      rx[2] = 8'd5;  ry[2] = 7'd5;  rw[2] = 8'd1; rh[2] = 7'd1; rc[2] = 3'd5;
      req = 4'b0001;
      nl = 0;
      step(); step();
      req[2] = 1'b1;
      step(); step();
      req[2] = 1'b0;
      repeat (10) step();
      chk("t4_ack0", ack_l[0], 4'b0001);
      chk("t4_done0", done_l[9], 4'b0001);
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 14; i++) begin
         if (ack_l[i][2]) cnt++;
         if (done_l[i][2]) cnt2++;
      end
      chk("t4_no_ack2", cnt, 0);
      chk("t4_no_done2", cnt2, 0);

      // Round-robin with all requesters held
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rx[i] = 8'(i * 20); ry[i] = 7'(i * 10);
         rw[i] = 8'd1; rh[i] = 7'd1; rc[i] = 3'(i + 1);
      end
      hold = 1;
      req = 4'b1111;
      nl = 0;
      na = 0;
      for (int s = 0; s < 30 && na < 5; s++) begin
         step();
         if (ack != 0) begin
            for (int b = 0; b < 4; b++) if (ack[b]) ord[na] = b;
            pos[na] = nl;
            na++;
         end
      end
      req = '0;
      hold = 0;
      chk("t5_grants", na, 5);
      for (int k = 0; k < 5; k++) begin
         if (k < na) chk($sformatf("t5_ord%0d", k), ord[k], rr_ord[k]);
         if (k > 0 && k < na) chk($sformatf("t5_gap%0d", k), pos[k] - pos[k-1], 3);
      end
      repeat (4) step();

      // Reset in the middle of a 4x4 draw
      rx[2] = 8'd70; ry[2] = 7'd80; rw[2] = 8'd4; rh[2] = 7'd4; rc[2] = 3'd6;
      req = 4'b0100;
      nl = 0;
      repeat (5) step();
      chk("t6_ack", ack_l[0], 4'b0100);
      chk("t6_px5", {plot_l[4], x_l[4], y_l[4]}, {1'b1, 8'd70, 7'd81});
      #2 rst = 1'b0;
      req = '0;
      #1;
      chk("t6_rst_ctl", {ack, done, busy, plot}, 0);
      chk("t6_rst_xyc", {x, y, colour}, 0);
      step(); step();
      chk("t6_no_done", done_l[5] | done_l[6], 0);
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rw[i] = 8'd1; rh[i] = 7'd1;
      end
      req = 4'b1010;
      nl = 0;
      repeat (7) step();
      chk("t6_first_grant", ack_l[0], 4'b0010);
      chk("t6_second_grant", ack_l[3], 4'b1000);
      req = '0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
